// File: rtl/wordle_judge_if.sv
// Setter/entry-side bus of the Wordle judge: secret load, guess handshake and scoring results.
// The master side (setter and guess entry) drives the inputs; the judge is the slave.
interface wordle_judge_if #(
  parameter int TIMES_W = 4
);
  logic [19:0]        secret;
  logic [TIMES_W-1:0] max_times;
  logic               secret_load;
  logic [19:0]        guess;
  logic               guess_valid;
  logic               guess_ready;
  logic               result_valid;
  logic               invalid_guess;
  logic               cfg_error;
  logic [1:0]         led0_in;
  logic [1:0]         led1_in;
  logic [1:0]         led2_in;
  logic [1:0]         led3_in;
  logic [1:0]         led4_in;
  logic [TIMES_W-1:0] times_left;
  logic               is_win;
  logic               is_over;

  modport master (
    output secret, max_times, secret_load, guess, guess_valid,
    input  guess_ready, result_valid, invalid_guess, cfg_error,
           led0_in, led1_in, led2_in, led3_in, led4_in,
           times_left, is_win, is_over
  );

  modport slave (
    input  secret, max_times, secret_load, guess, guess_valid,
    output guess_ready, result_valid, invalid_guess, cfg_error,
           led0_in, led1_in, led2_in, led3_in, led4_in,
           times_left, is_win, is_over
  );
endinterface

// File: rtl/wordle_judge.sv
// Wordle scoring responder: judges one guess digit per cycle and publishes LEDs/flags at once.
// Optional GUESS_DUP_CHECK_EN rejects guesses containing a repeated digit.
module wordle_judge #(
  parameter int TIMES_W   = 4,
  parameter int DIGIT_MAX = 9
) (
  input logic           clk,
  input logic           rst,
  wordle_judge_if.slave bus
);
  // state | meaning
  // IDLE  | no valid secret loaded
  // READY | waiting for a guess
  // SCORE | scanning the latched guess, one digit per cycle
  // OVER  | game decided, outputs frozen until a new secret
  typedef enum logic [1:0] {IDLE, READY, SCORE, OVER} state_t;

  localparam logic [9:0] LEDS_BLANK = 10'h3FF;
  localparam logic [9:0] ALL_EXACT  = 10'b10_10_10_10_10;

  state_t             state_q, state_d;
  logic [19:0]        secret_q, secret_d;
  logic [19:0]        guess_q, guess_d;
  logic [2:0]         idx_q, idx_d;
  logic [9:0]         shadow_q, shadow_d;
  logic [9:0]         led_q, led_d;
  logic [TIMES_W-1:0] times_q, times_d;
  logic               win_q, win_d;
  logic               over_q, over_d;
  logic               rv_q, rv_d;
  logic               inv_q, inv_d;
  logic               cfg_q, cfg_d;

  logic [3:0]         cur_guess, cur_secret;
  logic [1:0]         code;
  logic [TIMES_W-1:0] times_dec;
  logic               secret_ok, guess_ok;

  function automatic logic in_range(input logic [19:0] v);
    in_range = 1'b1;
    for (int k = 0; k < 5; k++)
      if (v[4*k +: 4] > 4'(DIGIT_MAX)) in_range = 1'b0;
  endfunction

  function automatic logic distinct(input logic [19:0] v);
    distinct = 1'b1;
    for (int j = 0; j < 5; j++)
      for (int k = j + 1; k < 5; k++)
        if (v[4*j +: 4] == v[4*k +: 4]) distinct = 1'b0;
  endfunction

  assign secret_ok = in_range(bus.secret) && distinct(bus.secret) && (bus.max_times != '0);
`ifdef GUESS_DUP_CHECK_EN
  assign guess_ok = in_range(bus.guess) && distinct(bus.guess);
`else
  assign guess_ok = in_range(bus.guess);
`endif

  assign cur_guess  = 4'(guess_q >> {idx_q, 2'b00});
  assign cur_secret = 4'(secret_q >> {idx_q, 2'b00});
  assign times_dec  = (times_q == '0) ? '0 : times_q - 1'b1;

  // exact position wins over "present elsewhere"
  always_comb begin
    code = 2'b00;
    for (int j = 0; j < 5; j++)
      if (secret_q[4*j +: 4] == cur_guess) code = 2'b01;
    if (cur_secret == cur_guess) code = 2'b10;
  end

  always_comb begin
    state_d  = state_q;
    secret_d = secret_q;
    guess_d  = guess_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    led_d    = led_q;
    times_d  = times_q;
    win_d    = win_q;
    over_d   = over_q;
    rv_d     = 1'b0;
    inv_d    = 1'b0;
    cfg_d    = 1'b0;

    if (bus.secret_load) begin
      led_d  = LEDS_BLANK;
      win_d  = 1'b0;
      over_d = 1'b0;
      idx_d  = '0;
      if (secret_ok) begin
        secret_d = bus.secret;
        times_d  = bus.max_times;
        state_d  = READY;
      end else begin
        cfg_d   = 1'b1;
        times_d = '0;
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        READY: begin
          if (bus.guess_valid) begin
            if (!guess_ok) begin
              inv_d = 1'b1;
            end else begin
              guess_d = bus.guess;
              idx_d   = '0;
              state_d = SCORE;
            end
          end
        end
        SCORE: begin
          shadow_d[{idx_q, 1'b0} +: 2] = code;
          if (idx_q == 3'd4) begin
            led_d   = shadow_d;
            rv_d    = 1'b1;
            times_d = times_dec;
            win_d   = (shadow_d == ALL_EXACT);
            over_d  = (shadow_d == ALL_EXACT) || (times_dec == '0);
            state_d = ((shadow_d == ALL_EXACT) || (times_dec == '0)) ? OVER : READY;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      secret_q <= '0;
      guess_q  <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      led_q    <= LEDS_BLANK;
      times_q  <= '0;
      win_q    <= 1'b0;
      over_q   <= 1'b0;
      rv_q     <= 1'b0;
      inv_q    <= 1'b0;
      cfg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      secret_q <= secret_d;
      guess_q  <= guess_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      led_q    <= led_d;
      times_q  <= times_d;
      win_q    <= win_d;
      over_q   <= over_d;
      rv_q     <= rv_d;
      inv_q    <= inv_d;
      cfg_q    <= cfg_d;
    end
  end

  assign bus.guess_ready   = (state_q == READY);
  assign bus.result_valid  = rv_q;
  assign bus.invalid_guess = inv_q;
  assign bus.cfg_error     = cfg_q;
  assign bus.led0_in       = led_q[1:0];
  assign bus.led1_in       = led_q[3:2];
  assign bus.led2_in       = led_q[5:4];
  assign bus.led3_in       = led_q[7:6];
  assign bus.led4_in       = led_q[9:8];
  assign bus.times_left    = times_q;
  assign bus.is_win        = win_q;
  assign bus.is_over       = over_q;
endmodule

// File: tb/tb_wordle_judge.sv
// Self-checking bench for wordle_judge: game-level model compared every cycle plus literal pins.
module tb_wordle_judge;
  localparam int TW = 4;
  localparam int PH_IDLE = 0, PH_READY = 1, PH_SCORE = 2, PH_OVER = 3;
`ifdef GUESS_DUP_CHECK_EN
  localparam bit DUP_REJECT = 1'b1;
`else
  localparam bit DUP_REJECT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  wordle_judge_if #(.TIMES_W(TW)) bus ();
  wordle_judge #(.TIMES_W(TW), .DIGIT_MAX(9)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [9:0] led_vec;
  assign led_vec = {bus.led4_in, bus.led3_in, bus.led2_in, bus.led1_in, bus.led0_in};

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // game-level model: what the block must show, from the rules of the game
  int       m_sec[5];
  int       m_led[5];
  int       pend[5];
  int       m_times = 0;
  bit       m_win = 0, m_over = 0, m_rv = 0, m_inv = 0, m_cfg = 0;
  int       m_phase = PH_IDLE;
  int       pub_cyc = -1;
  int       cyc = 0;
  bit       cmp_en = 0;

  function automatic int digit(input logic [19:0] v, input int k);
    return int'((v >> (4 * k)) & 20'hF);
  endfunction

  function automatic bit digits_ok(input logic [19:0] v, input bit need_distinct);
    int d[5];
    for (int k = 0; k < 5; k++) begin
      d[k] = digit(v, k);
      if (d[k] > 9) return 0;
    end
    if (need_distinct)
      for (int a = 0; a < 5; a++)
        for (int b = a + 1; b < 5; b++)
          if (d[a] == d[b]) return 0;
    return 1;
  endfunction

  function automatic void clear_game();
    m_times = 0; m_win = 0; m_over = 0;
    for (int k = 0; k < 5; k++) m_led[k] = 3;
  endfunction

  function automatic logic [9:0] model_leds();
    logic [9:0] v;
    v = '0;
    for (int k = 0; k < 5; k++) v[2*k +: 2] = 2'(m_led[k]);
    return v;
  endfunction

  function automatic void model_update();
    int nxt;
    int g;
    bit all_exact;
    nxt = cyc + 1;
    m_rv = 0; m_inv = 0; m_cfg = 0;
    if (rst) begin
      clear_game();
      m_phase = PH_IDLE;
    end else if (bus.secret_load) begin
      if (digits_ok(bus.secret, 1) && bus.max_times != 0) begin
        clear_game();
        for (int k = 0; k < 5; k++) m_sec[k] = digit(bus.secret, k);
        m_times = int'(bus.max_times);
        m_phase = PH_READY;
      end else begin
        clear_game();
        m_cfg = 1;
        m_phase = PH_IDLE;
      end
    end else if (m_phase == PH_READY && bus.guess_valid) begin
      if (!digits_ok(bus.guess, DUP_REJECT)) begin
        m_inv = 1;
      end else begin
        for (int k = 0; k < 5; k++) begin
          g = digit(bus.guess, k);
          pend[k] = 0;
          for (int j = 0; j < 5; j++) if (m_sec[j] == g) pend[k] = 1;
          if (m_sec[k] == g) pend[k] = 2;
        end
        m_phase = PH_SCORE;
        pub_cyc = cyc + 6;
      end
    end else if (m_phase == PH_SCORE && nxt == pub_cyc) begin
      all_exact = 1;
      for (int k = 0; k < 5; k++) begin
        m_led[k] = pend[k];
        if (pend[k] != 2) all_exact = 0;
      end
      m_times = (m_times > 0) ? m_times - 1 : 0;
      m_win   = all_exact;
      m_over  = all_exact || (m_times == 0);
      m_phase = m_over ? PH_OVER : PH_READY;
      m_rv    = 1;
    end
    cyc = nxt;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("guess_ready", 32'(bus.guess_ready), 32'(m_phase == PH_READY));
      chk("result_valid", 32'(bus.result_valid), 32'(m_rv));
      chk("invalid_guess", 32'(bus.invalid_guess), 32'(m_inv));
      chk("cfg_error", 32'(bus.cfg_error), 32'(m_cfg));
      chk("leds", 32'(led_vec), 32'(model_leds()));
      chk("times_left", 32'(bus.times_left), 32'(m_times));
      chk("is_win", 32'(bus.is_win), 32'(m_win));
      chk("is_over", 32'(bus.is_over), 32'(m_over));
    end
  end

  task automatic clk_step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) clk_step();
  endtask

  task automatic load(input logic [19:0] sec, input logic [TW-1:0] mt);
    bus.secret = sec; bus.max_times = mt; bus.secret_load = 1'b1;
    clk_step();
    bus.secret_load = 1'b0;
  endtask

  task automatic offer(input logic [19:0] g);
    bus.guess = g; bus.guess_valid = 1'b1;
    clk_step();
    bus.guess_valid = 1'b0;
  endtask

  initial begin
    bus.secret = '0; bus.max_times = '0; bus.secret_load = 1'b0;
    bus.guess = '0; bus.guess_valid = 1'b0;
    rst = 1'b1;
    steps(2);
    cmp_en = 1;
    clk_step();
    rst = 1'b0;
    chk("rst_leds", 32'(led_vec), 32'h3FF);
    chk("rst_ready", 32'(bus.guess_ready), 32'd0);

    // mixed result; a guess offered mid-scoring is ignored
    load(20'h01234, 4'd3);
    offer(20'h43210);
    clk_step();
    offer(20'h98765);
    steps(3);
    chk("t1_rv", 32'(bus.result_valid), 32'd1);
    chk("t1_leds", 32'(led_vec), 32'(10'b01_01_10_01_01));
    chk("t1_times", 32'(bus.times_left), 32'd2);

    // win
    offer(20'h01234);
    steps(5);
    chk("t2_leds", 32'(led_vec), 32'(10'b10_10_10_10_10));
    chk("t2_flags", 32'({bus.is_win, bus.is_over}), 32'b11);
    chk("t2_times", 32'(bus.times_left), 32'd1);
    clk_step();
    offer(20'h43210);
    steps(3);
    chk("t2_ready_after", 32'(bus.guess_ready), 32'd0);

    // budget exhausted with nothing matching
    load(20'h01234, 4'd1);
    offer(20'h56789);
    steps(5);
    chk("t3_leds", 32'(led_vec), 32'd0);
    chk("t3_state", 32'({bus.is_win, bus.is_over, bus.times_left}), 32'b0_1_0000);
    offer(20'h01234);
    steps(7);

    // mixed pattern on another secret
    load(20'h97531, 4'd4);
    offer(20'h95132);
    steps(5);
    chk("t3b_leds", 32'(led_vec), 32'(10'b10_01_01_10_00));

    // out-of-range and repeated-digit guesses
    load(20'h01234, 4'd3);
    offer(20'h43210);
    steps(5);
    offer(20'h0123A);
    chk("t4_inv", 32'(bus.invalid_guess), 32'd1);
    chk("t4_leds_kept", 32'(led_vec), 32'(10'b01_01_10_01_01));
    chk("t4_times_kept", 32'(bus.times_left), 32'd2);
    clk_step();
    offer(20'h01123);
`ifdef GUESS_DUP_CHECK_EN
    chk("t4_dup_inv", 32'(bus.invalid_guess), 32'd1);
    steps(5);
    chk("t4_dup_leds", 32'(led_vec), 32'(10'b01_01_10_01_01));
`else
    chk("t4_dup_inv", 32'(bus.invalid_guess), 32'd0);
    steps(5);
    chk("t4_dup_leds", 32'(led_vec), 32'(10'b10_10_01_01_01));
    chk("t4_dup_times", 32'(bus.times_left), 32'd1);
`endif
    clk_step();

    // rejected secrets
    load(20'h01134, 4'd3);
    chk("t5_cfg_dup", 32'(bus.cfg_error), 32'd1);
    chk("t5_ready", 32'(bus.guess_ready), 32'd0);
    clk_step();
    load(20'h01234, 4'd0);
    chk("t5_cfg_zero", 32'(bus.cfg_error), 32'd1);
    load(20'h0123B, 4'd2);
    chk("t5_cfg_range", 32'(bus.cfg_error), 32'd1);
    offer(20'h01234);
    steps(2);

    // reload during scoring aborts the pass
    load(20'h01234, 4'd3);
    offer(20'h43210);
    steps(2);
    load(20'h56789, 4'd5);
    chk("t6_ready", 32'(bus.guess_ready), 32'd1);
    chk("t6_times", 32'(bus.times_left), 32'd5);
    chk("t6_leds", 32'(led_vec), 32'h3FF);
    steps(5);

    // reset during scoring
    offer(20'h98765);
    steps(2);
    rst = 1'b1;
    clk_step();
    rst = 1'b0;
    chk("t6_rst_leds", 32'(led_vec), 32'h3FF);
    chk("t6_rst_ready", 32'(bus.guess_ready), 32'd0);
    steps(6);

    cmp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
